guess_capture: RTL and testbench
================================

GUESS_CAPTURE -- requirements
Module: guess_capture

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 1000000, the number of clk cycles a level must stay stable to count as debounced (minimum 2).
REQ-002 SHALL provide parameter MAX_GUESSES, default 6, the guesses allowed per round (range 1..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Port clk, input, 1 bit, rising-edge system clock.
REQ-004 SHALL provide port Reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL provide ports A, B, C, D, input, 4 bits each, raw guess digit switches.
REQ-006 SHALL provide port Enter, input, 1 bit, raw bouncing pushbutton.
REQ-007 SHALL provide port new_round, input, 1 bit, synchronous round restart.
REQ-008 SHALL provide port guess_ready, input, 1 bit, comparator accepts the guess.
REQ-009 SHALL provide port guess_valid, output, 1 bit, a captured guess is pending.
REQ-010 SHALL provide port guess_out, output, 16 bits, {A,B,C,D} captured at press time.
REQ-011 SHALL provide port enter_pulse, output, 1 bit, one-cycle debounced press strobe.
REQ-012 SHALL provide port guess_count, output, 4 bits, guesses captured this round.
REQ-013 SHALL provide port overrun, output, 1 bit, sticky flag for a press dropped while a guess was pending.
REQ-014 SHALL provide port out_of_guesses, output, 1 bit, the round guess limit has been reached.

Function
REQ-015 SHALL pass A..D and Enter through 2-flop synchronizers before any use.
REQ-016 SHALL implement the debounce FSM as IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE -> PRESS_WAIT when synced Enter = 1; counter clears.
- PRESS_WAIT -> IDLE if Enter = 0 before the counter reaches DB_CYCLES-1.
- PRESS_WAIT -> PRESSED when the counter reaches DB_CYCLES-1.
- PRESSED -> RELEASE_WAIT when Enter = 0.
- RELEASE_WAIT -> PRESSED if Enter = 1.
- RELEASE_WAIT -> IDLE after DB_CYCLES stable low cycles.
REQ-017 SHALL assert enter_pulse for exactly one cycle, on the transition into PRESSED only. A held button yields one pulse.
REQ-018 SHALL assert the first enter_pulse on clk edge DB_CYCLES+3, counting from the first edge that samples a stable Enter = 1.
REQ-019 On enter_pulse with guess_valid = 0, SHALL latch the synced {A,B,C,D} into guess_out, set guess_valid the next cycle, and increment guess_count, saturating at 15.
REQ-020 On enter_pulse with guess_valid = 1 and no same-cycle accept, SHALL drop the press, leave guess_out and guess_count unchanged, and set overrun.
REQ-021 SHALL treat guess_valid & guess_ready as a transfer. guess_valid clears next cycle; guess_out stays stable while guess_valid = 1.
REQ-022 If a transfer and enter_pulse occur in the same cycle, SHALL capture the new guess and keep guess_valid = 1.
REQ-023 new_round SHALL clear guess_valid, guess_count, overrun and out_of_guesses next cycle, with priority over capture and transfer. The debounce FSM is unaffected.

Reset
REQ-024 While Reset = 1, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counter and synchronizers SHALL be 0.
REQ-025 Reset asserted mid-debounce or mid-handshake SHALL abort immediately. A button still held at release of Reset SHALL be debounced afresh.

Configuration
REQ-026 Macro GUESS_LIMIT_EN, when defined:
- out_of_guesses = (guess_count == MAX_GUESSES).
- While out_of_guesses = 1, presses SHALL be ignored: no capture, no overrun.
REQ-027 Without GUESS_LIMIT_EN:
- out_of_guesses SHALL be tied to 0.
- Captures are unlimited, with guess_count saturating at 15.

Structure
REQ-028 Package octurdle_pkg SHALL hold the debounce state enum, DIGIT_W=4, GUESS_W=16 and the default DB_CYCLES/MAX_GUESSES constants.
REQ-029 Sub-module btn_debounce SHALL contain the synchronizer, FSM, counter and one-shot, instantiated once for Enter. guess_capture holds the capture, handshake and counters.

Verification (bench uses DB_CYCLES=4, MAX_GUESSES=3)
REQ-030 Clean press, A..D=1,2,3,4 -> one enter_pulse at cycle 7; guess_out=16'h1234, guess_valid=1, guess_count=1.
REQ-031 Enter toggling every 2 cycles for 20 cycles, then low -> no enter_pulse and guess_count stays 0.
REQ-032 Two presses with guess_ready=0 -> guess_out keeps the first value, overrun=1, guess_count=1; one guess_ready cycle -> guess_valid=0.
REQ-033 With GUESS_LIMIT_EN: 4 accepted presses -> guess_count=3, out_of_guesses=1, 4th ignored; new_round -> count 0, flag 0.
REQ-034 Reset pulse during PRESS_WAIT with Enter held -> outputs 0; after release, enter_pulse at cycle 7 after release.
REQ-035 enter_pulse in the same cycle as guess_valid&guess_ready -> new guess latched, guess_valid stays 1, overrun=0.

Source files
------------

// File: rtl/octurdle_pkg.sv
// Shared types and constants for the guess capture front end.
// Holds the debounce state encoding and the default sizing constants.
package octurdle_pkg;

  localparam int DIGIT_W         = 4;
  localparam int GUESS_W         = 16;
  localparam int DB_CYCLES_DEF   = 1000000;
  localparam int MAX_GUESSES_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-flop sync, 4-state FSM, counter, one-shot.
// Ports: clk, rst (async high), raw (bouncing input), pulse (1-cycle strobe).
module btn_debounce
  import octurdle_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] PLAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] RLAST = CW'(DB_CYCLES - 2);

  logic [1:0]    sync;
  logic          in;
  db_state_t     state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fire;

  assign in = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= nxt;
      cnt   <= cnt_nxt;
      pulse <= fire;
    end
  end

  // Release bounce (RELEASE_WAIT -> PRESSED) must not fire again,
  // so the strobe comes only from the PRESS_WAIT exit.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in) begin
          nxt     = PRESS_WAIT;
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!in) begin
          nxt = IDLE;
        end else if (cnt == PLAST) begin
          nxt  = PRESSED;
          fire = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!in) begin
          nxt     = RELEASE_WAIT;
          cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        // The edge entering this state was the first low sample.
        if (in) begin
          nxt = PRESSED;
        end else if (cnt == RLAST) begin
          nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/guess_capture.sv
// Captures a 4-digit guess on a debounced Enter press, valid/ready out.
// Ports: clk, Reset, A..D, Enter, new_round, guess_ready in; guess_valid,
// guess_out, enter_pulse, guess_count, overrun, out_of_guesses out.
// Option: define GUESS_LIMIT_EN to enforce MAX_GUESSES per round.
module guess_capture
  import octurdle_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int MAX_GUESSES = MAX_GUESSES_DEF
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [DIGIT_W-1:0] A,
  input  logic [DIGIT_W-1:0] B,
  input  logic [DIGIT_W-1:0] C,
  input  logic [DIGIT_W-1:0] D,
  input  logic               Enter,
  input  logic               new_round,
  input  logic               guess_ready,
  output logic               guess_valid,
  output logic [GUESS_W-1:0] guess_out,
  output logic               enter_pulse,
  output logic [3:0]         guess_count,
  output logic               overrun,
  output logic               out_of_guesses
);

  logic [GUESS_W-1:0] s1, s2;
  logic               xfer, take, drop;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk  (clk),
    .rst  (Reset),
    .raw  (Enter),
    .pulse(enter_pulse)
  );

`ifdef GUESS_LIMIT_EN
  assign out_of_guesses = (guess_count == 4'(MAX_GUESSES));
`else
  assign out_of_guesses = 1'b0;
`endif

  assign xfer = guess_valid & guess_ready;
  assign take = enter_pulse & ~out_of_guesses
              & (~guess_valid | xfer);
  assign drop = enter_pulse & ~out_of_guesses
              & guess_valid & ~xfer;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1          <= '0;
      s2          <= '0;
      guess_out   <= '0;
      guess_valid <= 1'b0;
      guess_count <= '0;
      overrun     <= 1'b0;
    end else begin
      s1 <= {A, B, C, D};
      s2 <= s1;
      if (new_round) begin
        guess_valid <= 1'b0;
        guess_count <= '0;
        overrun     <= 1'b0;
      end else begin
        if (take) begin
          guess_out   <= s2;
          guess_valid <= 1'b1;
          if (guess_count != 4'hF)
            guess_count <= guess_count + 4'd1;
        end else if (xfer) begin
          guess_valid <= 1'b0;
        end
        if (drop)
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_guess_capture.sv
// Directed self-checking bench for guess_capture (DB_CYCLES=4,
// MAX_GUESSES=3); expected values are hand-computed constants.
module tb_guess_capture;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  A, B, C, D;
  logic        Enter, new_round, guess_ready;
  logic        guess_valid, enter_pulse, overrun, out_of_guesses;
  logic [15:0] guess_out;
  logic [3:0]  guess_count;

  int errs   = 0;
  int checks = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  always @(posedge clk) if (enter_pulse) pulses++;

  guess_capture #(.DB_CYCLES(4), .MAX_GUESSES(3)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .A             (A),
    .B             (B),
    .C             (C),
    .D             (D),
    .Enter         (Enter),
    .new_round     (new_round),
    .guess_ready   (guess_ready),
    .guess_valid   (guess_valid),
    .guess_out     (guess_out),
    .enter_pulse   (enter_pulse),
    .guess_count   (guess_count),
    .overrun       (overrun),
    .out_of_guesses(out_of_guesses)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_guess(input logic [15:0] g);
    {A, B, C, D} = g;
  endtask

  task automatic press(input logic [15:0] g);
    set_guess(g);
    Enter = 1'b1;
    tick(10);
    Enter = 1'b0;
    tick(12);
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    tick(1);
    guess_ready = 1'b0;
  endtask

  task automatic restart();
    new_round = 1'b1;
    tick(1);
    new_round = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, guess_valid, 0);
    check({tag, "_out"}, guess_out, 0);
    check({tag, "_pulse"}, enter_pulse, 0);
    check({tag, "_count"}, guess_count, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_oog"}, out_of_guesses, 0);
  endtask

  initial begin
    Reset = 1'b1;
    {A, B, C, D} = '0;
    Enter = 1'b0;
    new_round = 1'b0;
    guess_ready = 1'b0;
    tick(3);
    check_zero("rst");
    Reset = 1'b0;
    tick(2);

    // bouncing Enter never reaches the debounce threshold
    p0 = pulses;
    set_guess(16'hFEDC);
    for (int i = 0; i < 10; i++) begin
      Enter = ~Enter;
      tick(2);
    end
    Enter = 1'b0;
    tick(12);
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_count", guess_count, 0);
    check("bounce_valid", guess_valid, 0);

    // clean press: strobe after edge 7
    set_guess(16'h1234);
    tick(2);
    Enter = 1'b1;
    tick(6);
    check("clean_pre", enter_pulse, 0);
    tick(1);
    check("clean_pulse", enter_pulse, 1);
    tick(1);
    check("clean_one", enter_pulse, 0);
    check("clean_valid", guess_valid, 1);
    check("clean_out", guess_out, 16'h1234);
    check("clean_count", guess_count, 1);
    tick(8);
    Enter = 1'b0;
    tick(12);
    check("held_one_pulse", pulses - p0, 1);
    accept();
    check("acc_valid", guess_valid, 0);

    // overrun: second press while pending
    restart();
    check("nr_count", guess_count, 0);
    press(16'h5678);
    check("ov1_valid", guess_valid, 1);
    check("ov1_out", guess_out, 16'h5678);
    press(16'h9ABC);
    check("ov2_out", guess_out, 16'h5678);
    check("ov2_ovr", overrun, 1);
    check("ov2_count", guess_count, 1);
    accept();
    check("ov_acc_valid", guess_valid, 0);

    // capture coinciding with a transfer
    restart();
    check("nr_ovr", overrun, 0);
    press(16'h1111);
    set_guess(16'h2222);
    Enter = 1'b1;
    tick(7);
    check("same_pulse", enter_pulse, 1);
    check("same_pend", guess_valid, 1);
    guess_ready = 1'b1;
    tick(1);
    guess_ready = 1'b0;
    check("same_valid", guess_valid, 1);
    check("same_out", guess_out, 16'h2222);
    check("same_ovr", overrun, 0);
    check("same_count", guess_count, 2);
    tick(3);
    Enter = 1'b0;
    tick(12);
    accept();

    // round limit
    restart();
    press(16'hA001); accept();
    press(16'hA002); accept();
    press(16'hA003); accept();
    check("lim3_count", guess_count, 3);
`ifdef GUESS_LIMIT_EN
    check("lim3_oog", out_of_guesses, 1);
    press(16'hA004);
    check("lim4_count", guess_count, 3);
    check("lim4_valid", guess_valid, 0);
    check("lim4_ovr", overrun, 0);
    check("lim4_out", guess_out, 16'hA003);
`else
    check("lim3_oog", out_of_guesses, 0);
    press(16'hA004);
    check("lim4_count", guess_count, 4);
    check("lim4_valid", guess_valid, 1);
    check("lim4_out", guess_out, 16'hA004);
    accept();
`endif
    restart();
    check("lim_nr_count", guess_count, 0);
    check("lim_nr_oog", out_of_guesses, 0);

    // reset mid-debounce with Enter held
    set_guess(16'h4321);
    Enter = 1'b1;
    tick(4);
    Reset = 1'b1;
    #1;
    check_zero("mid");
    tick(2);
    Reset = 1'b0;
    tick(6);
    check("rr_pre", enter_pulse, 0);
    tick(1);
    check("rr_pulse", enter_pulse, 1);
    tick(1);
    check("rr_valid", guess_valid, 1);
    check("rr_out", guess_out, 16'h4321);
    check("rr_count", guess_count, 1);
    Enter = 1'b0;
    tick(12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
